// File: rtl/vend_controller.sv
// Vending-machine sequencing controller: credits coins into a quarter-granular
// balance, accepts purchases, holds the dispense strobe, then pays change back.
module vend_controller #(
    parameter int PRICE0      = 75,
    parameter int PRICE1      = 100,
    parameter int PRICE2      = 125,
    parameter int PRICE3      = 150,
    parameter int MAX_BALANCE = 250,
    parameter int VEND_CYCLES = 8,
    parameter int CHANGE_GAP  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_q,
    input  logic       coin_d,
    input  logic       sel_valid,
    input  logic [1:0] sel_id,
    input  logic       cancel,
    output logic [7:0] balance,
    output logic       busy,
    output logic       sel_ack,
    output logic       insufficient,
    output logic       vend,
    output logic [1:0] vend_id,
    output logic       coin_reject,
    output logic       change_q
);

    localparam int         CW   = $clog2(VEND_CYCLES + CHANGE_GAP + 1);
    localparam logic [8:0] MAX9 = 9'(MAX_BALANCE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND   = 2'd1,
        CHANGE = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    logic [7:0] price;
    logic       q_ok;
    logic       d_ok;
    logic [8:0] bal_q;
    logic [8:0] bal_qd;
    logic       coin_any;
    logic       coin_refused;

    always_comb begin
        price = 8'(PRICE0);
        case (sel_id)
            2'd0:    price = 8'(PRICE0);
            2'd1:    price = 8'(PRICE1);
            2'd2:    price = 8'(PRICE2);
            default: price = 8'(PRICE3);
        endcase
    end

    // Quarter is judged first; the dollar sees the balance after the quarter.
    always_comb begin
        q_ok         = coin_q && (({1'b0, balance} + 9'd25) <= MAX9);
        bal_q        = {1'b0, balance} + (q_ok ? 9'd25 : 9'd0);
        d_ok         = coin_d && ((bal_q + 9'd100) <= MAX9);
        bal_qd       = bal_q + (d_ok ? 9'd100 : 9'd0);
        coin_any     = coin_q | coin_d;
        coin_refused = (coin_q && !q_ok) || (coin_d && !d_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            balance      <= 8'd0;
            busy         <= 1'b0;
            sel_ack      <= 1'b0;
            insufficient <= 1'b0;
            vend         <= 1'b0;
            vend_id      <= 2'd0;
            coin_reject  <= 1'b0;
            change_q     <= 1'b0;
        end else begin
            sel_ack      <= 1'b0;
            insufficient <= 1'b0;
            coin_reject  <= 1'b0;
            change_q     <= 1'b0;
            case (state)
                IDLE: begin
                    if (cancel && balance != 8'd0) begin
                        state       <= CHANGE;
                        busy        <= 1'b1;
                        cnt         <= '0;
                        coin_reject <= coin_any;
                    end else if (sel_valid && balance >= price) begin
                        sel_ack     <= 1'b1;
                        balance     <= balance - price;
                        vend_id     <= sel_id;
                        state       <= VEND;
                        busy        <= 1'b1;
                        cnt         <= '0;
                        coin_reject <= coin_any;
                    end else begin
                        insufficient <= sel_valid;
                        balance      <= bal_qd[7:0];
                        coin_reject  <= coin_refused;
                    end
                end
                // First VEND cycle carries sel_ack; the strobe follows for VEND_CYCLES.
                VEND: begin
                    coin_reject <= coin_any;
                    if (cnt == CW'(VEND_CYCLES)) begin
                        vend <= 1'b0;
                        cnt  <= '0;
                        if (balance != 8'd0) begin
                            state <= CHANGE;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        vend <= 1'b1;
                        cnt  <= cnt + CW'(1);
                    end
                end
                CHANGE: begin
                    coin_reject <= coin_any;
                    if (balance == 8'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == CW'(CHANGE_GAP - 1)) begin
                        change_q <= 1'b1;
                        balance  <= balance - 8'd25;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: a timeline model fills expected outputs per cycle
// from the purchase/refund rules; a negedge process compares them to the DUT.
module tb_vend_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       coin_q, coin_d, sel_valid, cancel;
    logic [1:0] sel_id;
    logic [7:0] balance;
    logic       busy, sel_ack, insufficient, vend, coin_reject, change_q;
    logic [1:0] vend_id;

    vend_controller dut (
        .clk(clk), .rst_n(rst_n), .coin_q(coin_q), .coin_d(coin_d),
        .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel),
        .balance(balance), .busy(busy), .sel_ack(sel_ack),
        .insufficient(insufficient), .vend(vend), .vend_id(vend_id),
        .coin_reject(coin_reject), .change_q(change_q)
    );

    always #5 clk = ~clk;

    localparam int N = 1024;

    // Index p = outputs seen after the p-th rising edge since reset release.
    int exp_bal  [N];
    int exp_vid  [N];
    bit exp_busy [N];
    bit exp_ack  [N];
    bit exp_ins  [N];
    bit exp_vend [N];
    bit exp_rej  [N];
    bit exp_chg  [N];

    int p;
    bit chk_en;
    int n_checks;
    int n_fail;

    function automatic int price_of(input int id);
        case (id)
            0:       return 75;
            1:       return 100;
            2:       return 125;
            default: return 150;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at idx %0d: actual=%0d expected=%0d", name, p, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            exp_bal[i] = 0; exp_vid[i] = 0; exp_busy[i] = 0; exp_ack[i] = 0;
            exp_ins[i] = 0; exp_vend[i] = 0; exp_rej[i] = 0; exp_chg[i] = 0;
        end
    endtask

    // Refund of b starting at entry index e: one quarter every 4 cycles.
    task automatic fill_change(input int e, input int b);
        int n;
        n = b / 25;
        for (int j = e; j <= e + 4 * n; j++) begin
            exp_busy[j] = 1;
            exp_bal[j]  = b - 25 * ((j - e) / 4);
        end
        for (int i = 1; i <= n; i++) exp_chg[e + 4 * i] = 1;
    endtask

    task automatic fill_vend(input int k, input int b, input int id);
        for (int j = k; j <= k + 8; j++) begin
            exp_busy[j] = 1;
            exp_bal[j]  = b;
        end
        for (int j = k + 1; j <= k + 8; j++) begin
            exp_vend[j] = 1;
            exp_vid[j]  = id;
        end
        if (b > 0) fill_change(k + 9, b);
    endtask

    task automatic model_step(input int k, input bit q, input bit d, input bit sv,
                              input int sid, input bit c);
        int b;
        int nb;
        if (exp_busy[k-1]) begin
            if (q || d) exp_rej[k] = 1;
            if (!exp_busy[k]) exp_bal[k] = exp_bal[k-1];
        end else begin
            b = exp_bal[k-1];
            if (c && b > 0) begin
                if (q || d) exp_rej[k] = 1;
                fill_change(k, b);
            end else if (sv && b >= price_of(sid)) begin
                if (q || d) exp_rej[k] = 1;
                exp_ack[k] = 1;
                fill_vend(k, b - price_of(sid), sid);
            end else begin
                if (sv) exp_ins[k] = 1;
                nb = b;
                if (q) begin
                    if (nb + 25 <= 250) nb += 25; else exp_rej[k] = 1;
                end
                if (d) begin
                    if (nb + 100 <= 250) nb += 100; else exp_rej[k] = 1;
                end
                exp_bal[k] = nb;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("balance", int'(balance), exp_bal[p]);
            check("busy", int'(busy), int'(exp_busy[p]));
            check("sel_ack", int'(sel_ack), int'(exp_ack[p]));
            check("insufficient", int'(insufficient), int'(exp_ins[p]));
            check("vend", int'(vend), int'(exp_vend[p]));
            check("coin_reject", int'(coin_reject), int'(exp_rej[p]));
            check("change_q", int'(change_q), int'(exp_chg[p]));
            if (exp_vend[p]) check("vend_id", int'(vend_id), exp_vid[p]);
        end
    end

    task automatic tick(input bit q, input bit d, input bit sv, input int sid, input bit c);
        coin_q = q; coin_d = d; sel_valid = sv; sel_id = 2'(sid); cancel = c;
        p++;
        model_step(p, q, d, sv, sid, c);
        @(posedge clk);
        @(negedge clk);
        #1;
        coin_q = 0; coin_d = 0; sel_valid = 0; sel_id = 2'd0; cancel = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_balance"}, int'(balance), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_ack"}, int'(sel_ack), 0);
        check({tag, "_ins"}, int'(insufficient), 0);
        check({tag, "_vend"}, int'(vend), 0);
        check({tag, "_vend_id"}, int'(vend_id), 0);
        check({tag, "_rej"}, int'(coin_reject), 0);
        check({tag, "_chg"}, int'(change_q), 0);
    endtask

    initial begin
        rst_n = 0; coin_q = 0; coin_d = 0; sel_valid = 0; sel_id = 2'd0; cancel = 0;
        chk_en = 0; n_checks = 0; n_fail = 0; p = 0;
        model_clear();
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1; chk_en = 1;

        // three quarters
        tick(1, 0, 0, 0, 0); check("lit_q1_bal", int'(balance), 25);
        tick(1, 0, 0, 0, 0); check("lit_q2_bal", int'(balance), 50);
        tick(1, 0, 0, 0, 0); check("lit_q3_bal", int'(balance), 75);
        check("lit_q3_rej", int'(coin_reject), 0);
        // too little credit for product 1
        tick(0, 0, 1, 1, 0);
        check("lit_ins", int'(insufficient), 1);
        check("lit_ins_bal", int'(balance), 75);
        check("lit_ins_busy", int'(busy), 0);
        idle(1);
        // cancel refunds 75
        tick(0, 0, 0, 0, 1); check("lit_cancel_busy", int'(busy), 1);
        idle(14);
        check("lit_refund_bal", int'(balance), 0);
        // both coins in one cycle, then purchase of product 0
        tick(1, 1, 0, 0, 0); check("lit_both_bal", int'(balance), 125);
        tick(0, 0, 1, 0, 0);
        check("lit_ack", int'(sel_ack), 1);
        check("lit_ack_bal", int'(balance), 50);
        tick(1, 0, 1, 2, 0);
        check("lit_busy_rej", int'(coin_reject), 1);
        check("lit_busy_noack", int'(sel_ack), 0);
        idle(20);
        check("lit_vend0_done", int'(balance), 0);
        // fill to the ceiling
        tick(0, 1, 0, 0, 0);
        tick(0, 1, 0, 0, 0);
        tick(1, 1, 0, 0, 0);
        check("lit_qd_bal", int'(balance), 225);
        check("lit_qd_rej", int'(coin_reject), 1);
        tick(1, 0, 0, 0, 0); check("lit_max_bal", int'(balance), 250);
        tick(1, 0, 0, 0, 0);
        check("lit_over_rej", int'(coin_reject), 1);
        check("lit_over_bal", int'(balance), 250);
        tick(0, 1, 0, 0, 0);
        // product 3 leaves 100 of change; a dollar during change is refused
        tick(0, 0, 1, 3, 0); check("lit_p3_bal", int'(balance), 100);
        idle(12);
        tick(0, 1, 0, 0, 0);
        idle(15);
        // cancel with zero balance is ignored; the coin counts
        tick(1, 0, 0, 0, 1);
        check("lit_cancel0_bal", int'(balance), 25);
        check("lit_cancel0_busy", int'(busy), 0);
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        // cancel with a coin in the same cycle
        tick(1, 0, 0, 0, 1);
        check("lit_cq_rej", int'(coin_reject), 1);
        check("lit_cq_bal", int'(balance), 100);
        idle(5);
        tick(0, 1, 0, 0, 0);
        idle(12);
        // exact-price purchase goes straight back to idle
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0);
        idle(10);
        check("lit_exact_busy", int'(busy), 0);

        // asynchronous reset in the middle of a vend
        tick(0, 1, 0, 0, 0);
        tick(0, 0, 1, 1, 0);
        idle(3);
        chk_en = 0;
        #2 rst_n = 0;
        #1 check_all_zero("async");
        @(negedge clk);
        #1;
        rst_n = 1;
        model_clear();
        p = 0;
        chk_en = 1;
        tick(1, 0, 0, 0, 0); check("lit_post_rst_bal", int'(balance), 25);
        idle(2);
        chk_en = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
